// File: rtl/lc3_decode_pkg.sv
// Shared LC-3 decode types: opcode enum, control-field encodings and E_Control
// bit positions (also imported by the execute stage).
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } op_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCS1_OFF11 = 2'b00;
  localparam logic [1:0] PCS1_OFF9  = 2'b01;
  localparam logic [1:0] PCS1_OFF6  = 2'b10;
  localparam logic [1:0] PCS1_ZERO  = 2'b11;

  localparam logic PCS2_NPC  = 1'b1;
  localparam logic OP2_VSR2  = 1'b1;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_LEA = 2'b01;
  localparam logic [1:0] W_MEM = 2'b10;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int E_W        = 6;
  localparam int E_ALU_MSB  = 5;
  localparam int E_PCS1_MSB = 3;
  localparam int E_PCS2     = 1;
  localparam int E_OP2      = 0;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode -> execute/writeback/memory control mapping.
// The illegal output exists only with LC3_DECODE_ILLEGAL_EN.
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [3:0]     op,
  input  logic           imm_bit,
  output logic [E_W-1:0] e_ctrl,
  output logic [1:0]     w_ctrl,
  output logic           mem_ctrl
`ifdef LC3_DECODE_ILLEGAL_EN
  ,
  output logic           illegal
`endif
);

  logic [1:0] alu;
  logic [1:0] pcs1;
  logic       pcs2;
  logic       op2;
  logic       ill;

  always_comb begin
    alu      = ALU_ADD;
    pcs1     = PCS1_OFF11;
    pcs2     = 1'b0;
    op2      = 1'b0;
    w_ctrl   = W_ALU;
    mem_ctrl = 1'b0;
    ill      = 1'b0;
    case (op_e'(op))
      OP_ADD: op2 = ~imm_bit;
      OP_AND: begin alu = ALU_AND; op2 = ~imm_bit; end
      OP_NOT: alu = ALU_NOT;
      OP_BR:  begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; end
      OP_JMP: pcs1 = PCS1_ZERO;
      OP_LD:  begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; w_ctrl = W_MEM; end
      OP_LDR: begin pcs1 = PCS1_OFF6; w_ctrl = W_MEM; end
      OP_LDI: begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; w_ctrl = W_MEM; mem_ctrl = 1'b1; end
      OP_LEA: begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; w_ctrl = W_LEA; end
      OP_ST:  begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; end
      OP_STI: begin pcs1 = PCS1_OFF9; pcs2 = PCS2_NPC; mem_ctrl = 1'b1; end
      OP_STR: pcs1 = PCS1_OFF6;
      // 0100, 1000, 1101, 1111 leave every control at zero
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    e_ctrl                          = '0;
    e_ctrl[E_ALU_MSB -: 2]          = alu;
    e_ctrl[E_PCS1_MSB -: 2]         = pcs1;
    e_ctrl[E_PCS2]                  = pcs2;
    e_ctrl[E_OP2]                   = op2 & (op2 == OP2_VSR2);
  end

`ifdef LC3_DECODE_ILLEGAL_EN
  assign illegal = ill;
`else
  logic unused_ill;
  assign unused_ill = ill;
`endif

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers IR/next-PC and the decoded controls on enable.
// Define LC3_DECODE_ILLEGAL_EN to add the sticky illegal_op flag.
module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control
`ifdef LC3_DECODE_ILLEGAL_EN
  ,
  output logic        illegal_op
`endif
);

  logic [E_W-1:0] e_dec;
  logic [1:0]     w_dec;
  logic           mem_dec;

  logic [15:0]    ir_q, ir_d, npc_q, npc_d;
  logic [E_W-1:0] e_q, e_d;
  logic [1:0]     w_q, w_d;
  logic           mem_q, mem_d;

`ifdef LC3_DECODE_ILLEGAL_EN
  logic ill_dec, ill_q, ill_d;
`endif

  lc3_decode_ctrl u_ctrl (
    .op       (dout[15:12]),
    .imm_bit  (dout[5]),
    .e_ctrl   (e_dec),
    .w_ctrl   (w_dec),
    .mem_ctrl (mem_dec)
`ifdef LC3_DECODE_ILLEGAL_EN
    ,
    .illegal  (ill_dec)
`endif
  );

  // Stall simply holds every register; flushing is the controller's job.
  always_comb begin
    ir_d  = ir_q;
    npc_d = npc_q;
    e_d   = e_q;
    w_d   = w_q;
    mem_d = mem_q;
`ifdef LC3_DECODE_ILLEGAL_EN
    ill_d = ill_q;
`endif
    if (enable_decode) begin
      ir_d  = dout;
      npc_d = npc_in;
      e_d   = e_dec;
      w_d   = w_dec;
      mem_d = mem_dec;
`ifdef LC3_DECODE_ILLEGAL_EN
      ill_d = ill_q | ill_dec;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      npc_q <= '0;
      e_q   <= '0;
      w_q   <= '0;
      mem_q <= 1'b0;
`ifdef LC3_DECODE_ILLEGAL_EN
      ill_q <= 1'b0;
`endif
    end else begin
      ir_q  <= ir_d;
      npc_q <= npc_d;
      e_q   <= e_d;
      w_q   <= w_d;
      mem_q <= mem_d;
`ifdef LC3_DECODE_ILLEGAL_EN
      ill_q <= ill_d;
`endif
    end
  end

  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_Control   = e_q;
  assign W_Control   = w_q;
  assign Mem_Control = mem_q;
`ifdef LC3_DECODE_ILLEGAL_EN
  assign illegal_op  = ill_q;
`endif

endmodule
